// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with CDB completion and jump-triggered flush
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int RRN_W = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [XLEN-1:0]            alloc_address,
    input  logic [RRN_W-1:0]           alloc_arn,
    input  logic [RRN_W-1:0]           alloc_rrn,
    input  logic                       alloc_tag,
    input  logic                       alloc_ignore,
    input  logic                       cdb_valid,
    input  logic [RRN_W-1:0]           cdb_rrn,
    input  logic [XLEN-1:0]            cdb_data,
    input  logic                       cdb_jump,
    input  logic [XLEN-1:0]            cdb_jump_address,
    output logic                       commit_valid,
    input  logic                       commit_ready,
    output logic [RRN_W-1:0]           commit_arn,
    output logic [RRN_W-1:0]           commit_rrn,
    output logic [XLEN-1:0]            commit_data,
    output logic                       commit_tag,
    output logic                       flush_valid,
    output logic [XLEN-1:0]            flush_address,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0]  address;
        logic [RRN_W-1:0] arn;
        logic [RRN_W-1:0] rrn;
        logic             tag;
        logic             ignore;
        logic             finished;
        logic             jump;
        logic [XLEN-1:0]  jump_address;
        logic [XLEN-1:0]  data;
    } rob_record_t;

    rob_record_t      rob [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic full;
    logic head_done;
    logic pop;
    logic flush_now;
    logic alloc_fire;

    assign full         = (count == CW'(DEPTH));
    assign alloc_ready  = !full && !flush_valid;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign head_done    = valid[head] && rob[head].finished;
    assign commit_valid = head_done && !rob[head].ignore;
    assign pop          = (commit_valid && commit_ready) || (head_done && rob[head].ignore);
    assign flush_now    = pop && rob[head].jump;

    assign commit_arn  = rob[head].arn;
    assign commit_rrn  = rob[head].rrn;
    assign commit_data = rob[head].data;
    assign commit_tag  = rob[head].tag;

    // Record payload needs no reset: the valid bits alone decide liveness.
    always_ff @(posedge clk) begin
        if (cdb_valid && !flush_valid && !flush_now) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && rob[i].rrn == cdb_rrn) begin
                    rob[i].finished     <= 1'b1;
                    rob[i].data         <= cdb_data;
                    rob[i].jump         <= cdb_jump;
                    rob[i].jump_address <= cdb_jump_address;
                end
            end
        end
        if (alloc_fire && !flush_now) begin
            rob[tail] <= '{address: alloc_address, arn: alloc_arn, rrn: alloc_rrn,
                           tag: alloc_tag, ignore: alloc_ignore, default: '0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_valid   <= 1'b0;
            flush_address <= '0;
        end else if (flush_now) begin
            valid         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_valid   <= 1'b1;
            flush_address <= rob[head].jump_address;
        end else begin
            flush_valid <= 1'b0;
            // A pop frees head while an alloc fills tail; they never alias since count is 1..DEPTH-1.
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + CW'(alloc_fire) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        alloc_valid, alloc_ready;
    logic [31:0] alloc_address;
    logic [5:0]  alloc_arn, alloc_rrn;
    logic        alloc_tag, alloc_ignore;
    logic        cdb_valid;
    logic [5:0]  cdb_rrn;
    logic [31:0] cdb_data;
    logic        cdb_jump;
    logic [31:0] cdb_jump_address;
    logic        commit_valid, commit_ready;
    logic [5:0]  commit_arn, commit_rrn;
    logic [31:0] commit_data;
    logic        commit_tag;
    logic        flush_valid;
    logic [31:0] flush_address;
    logic [4:0]  count;

    int tests  = 0;
    int failed = 0;

    reorder_buffer #(.DEPTH(16), .XLEN(32), .RRN_W(6)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_address(alloc_address),
        .alloc_arn(alloc_arn), .alloc_rrn(alloc_rrn), .alloc_tag(alloc_tag), .alloc_ignore(alloc_ignore),
        .cdb_valid(cdb_valid), .cdb_rrn(cdb_rrn), .cdb_data(cdb_data), .cdb_jump(cdb_jump),
        .cdb_jump_address(cdb_jump_address),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_arn(commit_arn),
        .commit_rrn(commit_rrn), .commit_data(commit_data), .commit_tag(commit_tag),
        .flush_valid(flush_valid), .flush_address(flush_address), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_alloc(input logic [5:0] rrn, input logic [5:0] arn, input logic ign);
        alloc_valid   = 1'b1;
        alloc_rrn     = rrn;
        alloc_arn     = arn;
        alloc_ignore  = ign;
        alloc_tag     = rrn[0];
        alloc_address = 32'h1000 + {26'd0, rrn};
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [5:0] rrn, input logic [31:0] data, input logic jmp,
                          input logic [31:0] target);
        cdb_valid        = 1'b1;
        cdb_rrn          = rrn;
        cdb_data         = data;
        cdb_jump         = jmp;
        cdb_jump_address = target;
        tick();
        cdb_valid = 1'b0;
        cdb_jump  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        alloc_valid = 0; alloc_address = 0; alloc_arn = 0; alloc_rrn = 0; alloc_tag = 0; alloc_ignore = 0;
        cdb_valid = 0; cdb_rrn = 0; cdb_data = 0; cdb_jump = 0; cdb_jump_address = 0;
        commit_ready = 1'b1;
        #12;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("reset_commit_valid", 64'(commit_valid), 64'd0);
        chk("reset_flush_valid", 64'(flush_valid), 64'd0);
        chk("reset_flush_address", 64'(flush_address), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Out-of-order completion, in-order commit
        do_alloc(6'd33, 6'd1, 1'b0);
        do_alloc(6'd34, 6'd2, 1'b0);
        do_alloc(6'd35, 6'd3, 1'b0);
        chk("t1_count3", 64'(count), 64'd3);
        do_cdb(6'd35, 32'h10, 1'b0, 32'h0);
        chk("t1_no_commit_yet", 64'(commit_valid), 64'd0);
        do_cdb(6'd34, 32'h20, 1'b0, 32'h0);
        do_cdb(6'd33, 32'h30, 1'b0, 32'h0);
        chk("t1_c0_valid", 64'(commit_valid), 64'd1);
        chk("t1_c0_arn", 64'(commit_arn), 64'd1);
        chk("t1_c0_rrn", 64'(commit_rrn), 64'd33);
        chk("t1_c0_data", 64'(commit_data), 64'h30);
        tick();
        chk("t1_c1_arn", 64'(commit_arn), 64'd2);
        chk("t1_c1_data", 64'(commit_data), 64'h20);
        tick();
        chk("t1_c2_valid", 64'(commit_valid), 64'd1);
        chk("t1_c2_arn", 64'(commit_arn), 64'd3);
        chk("t1_c2_data", 64'(commit_data), 64'h10);
        tick();
        chk("t1_empty_valid", 64'(commit_valid), 64'd0);
        chk("t1_empty_count", 64'(count), 64'd0);

        // Fill to capacity, wrap the tail
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(6'(i), 6'(i), 1'b0);
        chk("t2_full_count", 64'(count), 64'd16);
        chk("t2_full_ready", 64'(alloc_ready), 64'd0);
        alloc_valid = 1'b1; alloc_rrn = 6'd50;
        tick();
        alloc_valid = 1'b0;
        chk("t2_17th_rejected", 64'(count), 64'd16);
        do_cdb(6'd0, 32'hAA, 1'b0, 32'h0);
        chk("t2_head_commit", 64'(commit_valid), 64'd1);
        chk("t2_head_data", 64'(commit_data), 64'hAA);
        tick();
        chk("t2_after_pop_count", 64'(count), 64'd15);
        chk("t2_after_pop_ready", 64'(alloc_ready), 64'd1);
        commit_ready = 1'b0;
        do_alloc(6'd20, 6'd20, 1'b0);
        chk("t2_refill_count", 64'(count), 64'd16);
        do_cdb(6'd20, 32'h77, 1'b0, 32'h0);
        for (int i = 1; i < 16; i++) do_cdb(6'(i), 32'h100 + 32'(i), 1'b0, 32'h0);
        commit_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("t2_drain_valid", 64'(commit_valid), 64'd1);
            chk("t2_drain_rrn", 64'(commit_rrn), (i < 16) ? 64'(i) : 64'd20);
            chk("t2_drain_data", 64'(commit_data), (i < 16) ? 64'(32'h100 + 32'(i)) : 64'h77);
            tick();
        end
        chk("t2_drained_count", 64'(count), 64'd0);

        // Ignored entry retires without commit, regardless of commit_ready
        do_reset();
        commit_ready = 1'b0;
        do_alloc(6'd40, 6'd5, 1'b1);
        chk("t3_count1", 64'(count), 64'd1);
        do_cdb(6'd40, 32'h5, 1'b0, 32'h0);
        chk("t3_no_commit", 64'(commit_valid), 64'd0);
        chk("t3_count_before_pop", 64'(count), 64'd1);
        tick();
        chk("t3_count0", 64'(count), 64'd0);

        // Jump at head flushes younger entries
        commit_ready = 1'b1;
        do_alloc(6'd41, 6'd7, 1'b0);
        do_alloc(6'd42, 6'd8, 1'b0);
        do_alloc(6'd43, 6'd9, 1'b0);
        do_alloc(6'd44, 6'd10, 1'b0);
        do_cdb(6'd41, 32'h55, 1'b1, 32'h0000_0200);
        alloc_valid = 1'b1; alloc_rrn = 6'd50;
        cdb_valid = 1'b1; cdb_rrn = 6'd42; cdb_data = 32'h99;
        #1;
        chk("t4_commit_valid", 64'(commit_valid), 64'd1);
        chk("t4_commit_rrn", 64'(commit_rrn), 64'd41);
        chk("t4_count4", 64'(count), 64'd4);
        tick();
        chk("t4_flush_valid", 64'(flush_valid), 64'd1);
        chk("t4_flush_address", 64'(flush_address), 64'h200);
        chk("t4_flush_count", 64'(count), 64'd0);
        chk("t4_flush_ready", 64'(alloc_ready), 64'd0);
        chk("t4_flush_commit", 64'(commit_valid), 64'd0);
        alloc_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        chk("t4_pulse_ends", 64'(flush_valid), 64'd0);
        chk("t4_post_count", 64'(count), 64'd0);
        chk("t4_post_ready", 64'(alloc_ready), 64'd1);

        // Backpressure on commit holds the head stable
        commit_ready = 1'b0;
        do_alloc(6'd45, 6'd9, 1'b0);
        do_cdb(6'd45, 32'hBEEF, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_valid", 64'(commit_valid), 64'd1);
            chk("t5_hold_arn", 64'(commit_arn), 64'd9);
            chk("t5_hold_data", 64'(commit_data), 64'hBEEF);
            chk("t5_hold_tag", 64'(commit_tag), 64'd1);
            chk("t5_hold_count", 64'(count), 64'd1);
            tick();
        end
        commit_ready = 1'b1;
        tick();
        chk("t5_popped", 64'(count), 64'd0);

        // Unmatched CDB, then asynchronous reset mid-stream
        do_alloc(6'd46, 6'd11, 1'b0);
        do_cdb(6'd63, 32'hDEAD, 1'b0, 32'h0);
        chk("t6_unmatched_commit", 64'(commit_valid), 64'd0);
        chk("t6_unmatched_count", 64'(count), 64'd1);
        do_alloc(6'd47, 6'd12, 1'b0);
        chk("t6_pre_reset_count", 64'(count), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_ready", 64'(alloc_ready), 64'd1);
        chk("t6_async_commit", 64'(commit_valid), 64'd0);
        chk("t6_async_flush", 64'(flush_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
